lsu: RTL and testbench

Load/store unit directly downstream of the execute-stage ALU. Takes the ALU's ADD result as the effective address for all RV32I loads and stores and runs a valid/ready handshake toward the pipeline. Drives a request/grant/response data-memory port with byte enables and lane-replicated store data. Returns sign- or zero-extended load data to writeback as a single-cycle pulse.

---
 rtl/lsu_pkg.sv | 48 ++++
 rtl/lsu_align.sv | 67 ++++++
 rtl/lsu.sv | 174 +++++++++++++++++
 tb/tb_lsu.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the load/store unit: RV32I funct3
//               width codes, FSM state encoding and decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

   // RV32I load/store width and sign codes
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } lsu_state_e;

   // Stores accept only B/H/W; loads additionally accept BU/HU
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      case (f3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = ~we;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Halfword needs addr[0]==0, word needs addr[1:0]==0
   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      logic mis;
      mis = 1'b0;
      case (f3[1:0])
         2'b01:   mis = lo[0];
         2'b10:   mis = (lo != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane logic. Request side builds byte enables
//               and lane-replicated store data; response side extracts and
//               sign/zero-extends the addressed byte/halfword of a load.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   input  logic [2:0]  ld_funct3_i,
   input  logic [1:0]  ld_addr_lo_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] ldata_o
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Byte enables and replicated store data from access size and low address bits
   always_comb begin
      be_o    = 4'b1111;
      wdata_o = wdata_i;
      case (funct3_i[1:0])
         2'b00: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
            wdata_o = {2{wdata_i[15:0]}};
         end
         default: begin
            be_o    = 4'b1111;
            wdata_o = wdata_i;
         end
      endcase
   end

   // Select the addressed lane of the read word and extend it to 32 bits
   always_comb begin
      w_byte  = rdata_i[7:0];
      case (ld_addr_lo_i)
         2'b00:   w_byte = rdata_i[7:0];
         2'b01:   w_byte = rdata_i[15:8];
         2'b10:   w_byte = rdata_i[23:16];
         default: w_byte = rdata_i[31:24];
      endcase
      w_half  = ld_addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      ldata_o = rdata_i;
      case (ld_funct3_i)
         F3_B:    ldata_o = {{24{w_byte[7]}}, w_byte};
         F3_BU:   ldata_o = {24'h000000, w_byte};
         F3_H:    ldata_o = {{16{w_half[15]}}, w_half};
         F3_HU:   ldata_o = {16'h0000, w_half};
         default: ldata_o = rdata_i;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : RV32I load/store unit. IDLE/REQ/RESP FSM with capture
//               registers driving a req/gnt/rvalid data-memory port and a
//               single-cycle writeback pulse.
//               Optional macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word
//               accesses raise exc_valid_o instead of going to memory.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu
   import lsu_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        mem_we_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  rd_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_gnt_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i,
   output logic        wb_valid_o,
   output logic [4:0]  wb_rd_o,
   output logic [31:0] wb_data_o,
   output logic        exc_valid_o,
   output logic [31:0] exc_addr_o
);

   lsu_state_e  state_q, state_d;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  addr_lo_q;
   logic [4:0]  rd_q;
   logic [31:0] dmem_addr_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;
   logic        wb_valid_q;
   logic [4:0]  wb_rd_q;
   logic [31:0] wb_data_q;

   logic        w_accept;
   logic        w_legal;
   logic        w_trap;
   logic        w_start;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_ldata;

   assign w_accept = req_valid_i && (state_q == ST_IDLE);
   assign w_legal  = f3_legal(mem_we_i, funct3_i);
   assign w_start  = w_accept && w_legal && !w_trap;

   lsu_align u_align (
      .funct3_i     (funct3_i),
      .addr_lo_i    (addr_i[1:0]),
      .wdata_i      (wdata_i),
      .be_o         (w_be),
      .wdata_o      (w_wdata),
      .ld_funct3_i  (f3_q),
      .ld_addr_lo_i (addr_lo_q),
      .rdata_i      (dmem_rdata_i),
      .ldata_o      (w_ldata)
   );

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next state and state-decoded handshake outputs
   always_comb begin
      state_d     = state_q;
      req_ready_o = 1'b0;
      dmem_req_o  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready_o = 1'b1;
            if (w_start) state_d = ST_REQ;
         end
         ST_REQ: begin
            dmem_req_o = 1'b1;
            if (dmem_gnt_i) state_d = we_q ? ST_IDLE : ST_RESP;
         end
         ST_RESP: begin
            if (dmem_rvalid_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Write strobe only accompanies an outstanding request
   assign dmem_we_o    = dmem_req_o && we_q;
   assign dmem_addr_o  = dmem_addr_q;
   assign dmem_be_o    = be_q;
   assign dmem_wdata_o = wdata_q;

   // Capture the accepted op; illegal or trapped ops leave these untouched
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         we_q        <= 1'b0;
         f3_q        <= 3'b000;
         addr_lo_q   <= 2'b00;
         rd_q        <= 5'd0;
         dmem_addr_q <= 32'h0;
         be_q        <= 4'h0;
         wdata_q     <= 32'h0;
      end else if (w_start) begin
         we_q        <= mem_we_i;
         f3_q        <= funct3_i;
         addr_lo_q   <= addr_i[1:0];
         rd_q        <= rd_i;
         dmem_addr_q <= {addr_i[31:2], 2'b00};
         be_q        <= w_be;
         wdata_q     <= w_wdata;
      end
   end

   // Register extended load data on rvalid; pulse is suppressed for x0
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wb_valid_q <= 1'b0;
         wb_rd_q    <= 5'd0;
         wb_data_q  <= 32'h0;
      end else begin
         wb_valid_q <= 1'b0;
         if ((state_q == ST_RESP) && dmem_rvalid_i) begin
            wb_valid_q <= (rd_q != 5'd0);
            wb_rd_q    <= rd_q;
            wb_data_q  <= w_ldata;
         end
      end
   end

   assign wb_valid_o = wb_valid_q;
   assign wb_rd_o    = wb_rd_q;
   assign wb_data_o  = wb_data_q;

`ifdef LSU_MISALIGN_TRAP_EN
   logic        exc_valid_q;
   logic [31:0] exc_addr_q;

   assign w_trap = w_accept && w_legal && f3_misaligned(funct3_i, addr_i[1:0]);

   // One-cycle exception pulse carrying the faulting address
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         exc_valid_q <= 1'b0;
         exc_addr_q  <= 32'h0;
      end else begin
         exc_valid_q <= w_trap;
         if (w_trap) exc_addr_q <= addr_i;
      end
   end

   assign exc_valid_o = exc_valid_q;
   assign exc_addr_o  = exc_addr_q;
`else
   assign w_trap      = 1'b0;
   assign exc_valid_o = 1'b0;
   assign exc_addr_o  = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu
// Description : Directed self-checking bench for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        mem_we;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [4:0]  rd;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        exc_valid;
   logic [31:0] exc_addr;

   int n_tests = 0;
   int n_fail  = 0;

   lsu u_dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .mem_we_i      (mem_we),
      .funct3_i      (funct3),
      .addr_i        (addr),
      .wdata_i       (wdata),
      .rd_i          (rd),
      .dmem_req_o    (dmem_req),
      .dmem_we_o     (dmem_we),
      .dmem_addr_o   (dmem_addr),
      .dmem_be_o     (dmem_be),
      .dmem_wdata_o  (dmem_wdata),
      .dmem_gnt_i    (dmem_gnt),
      .dmem_rvalid_i (dmem_rvalid),
      .dmem_rdata_i  (dmem_rdata),
      .wb_valid_o    (wb_valid),
      .wb_rd_o       (wb_rd),
      .wb_data_o     (wb_data),
      .exc_valid_o   (exc_valid),
      .exc_addr_o    (exc_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one op for a single cycle; returns in cycle 1 after the accept edge
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] r);
      req_valid = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd; rd = r;
      step();
      req_valid = 1'b0;
   endtask

   // Load with gw grant-wait and rw rvalid-wait cycles; observes 16 cycles
   task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] r,
                          input logic [31:0] rdv, input int gw, input int rw,
                          output int wbc, output int pulses, output int reqc,
                          output logic [31:0] wbd, output logic [4:0] wbr,
                          output logic [31:0] a1, output logic rdy);
      issue(1'b0, f3, a, 32'h0, r);
      wbc = -1; pulses = 0; reqc = 0; wbd = 32'h0; wbr = 5'd0; rdy = 1'b0;
      a1 = dmem_addr;
      for (int c = 1; c <= 16; c++) begin
         if (dmem_req) reqc++;
         if (wb_valid) begin
            pulses++;
            if (wbc < 0) begin
               wbc = c; wbd = wb_data; wbr = wb_rd; rdy = req_ready;
            end
         end
         dmem_gnt    = (c == 1 + gw);
         dmem_rvalid = (c == 2 + gw + rw);
         dmem_rdata  = dmem_rvalid ? rdv : 32'h0;
         step();
      end
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
   endtask

   // Store with gw grant-wait cycles; samples the port in cycle 1
   task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           input int gw, output logic [3:0] be1, output logic [31:0] wd1,
                           output logic [31:0] a1, output logic we1, output int rc);
      issue(1'b1, f3, a, wd, 5'd0);
      be1 = dmem_be; wd1 = dmem_wdata; a1 = dmem_addr; we1 = dmem_we;
      rc = -1;
      for (int c = 1; c <= 10; c++) begin
         if (req_ready && rc < 0) rc = c;
         dmem_gnt = (c == 1 + gw);
         step();
      end
      dmem_gnt = 1'b0;
   endtask

   int          wbc, pulses, reqc, rc;
   logic [31:0] wbd, a1, wd1;
   logic [4:0]  wbr;
   logic [3:0]  be1;
   logic        rdy, we1;

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; mem_we = 1'b0; funct3 = 3'b000; addr = 32'h0;
      wdata = 32'h0; rd = 5'd0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
      #2;
      check_eq("rst_ready", {31'h0, req_ready}, 32'h1);
      check_eq("rst_req",   {31'h0, dmem_req},  32'h0);
      check_eq("rst_wb",    {31'h0, wb_valid},  32'h0);
      check_eq("rst_addr",  dmem_addr,          32'h0);
      check_eq("rst_be",    {28'h0, dmem_be},   32'h0);
      check_eq("rst_exc",   {31'h0, exc_valid}, 32'h0);
      step(); step();
      rst_n = 1'b1;
      step();

      // SB to 0x1003
      do_store(F3_SB(), 32'h0000_1003, 32'h0000_00AB, 0, be1, wd1, a1, we1, rc);
      check_eq("sb_be",    {28'h0, be1}, 32'h8);
      check_eq("sb_wdata", wd1,          32'hABAB_ABAB);
      check_eq("sb_addr",  a1,           32'h0000_1000);
      check_eq("sb_we",    {31'h0, we1}, 32'h1);
      check_eq("sb_ready_cycle", rc,     32'd2);

      // SH to 0x1002, one grant-wait cycle
      do_store(3'b001, 32'h0000_1002, 32'h1234_BEEF, 1, be1, wd1, a1, we1, rc);
      check_eq("sh_be",    {28'h0, be1}, 32'hC);
      check_eq("sh_wdata", wd1,          32'hBEEF_BEEF);
      check_eq("sh_ready_cycle", rc,     32'd3);

      // SW to 0x1004
      do_store(3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 0, be1, wd1, a1, we1, rc);
      check_eq("sw_be",    {28'h0, be1}, 32'hF);
      check_eq("sw_wdata", wd1,          32'hDEAD_BEEF);

      // LB from 0x2001
      do_load(3'b000, 32'h0000_2001, 5'd5, 32'h0000_8000, 0, 0, wbc, pulses, reqc, wbd, wbr, a1, rdy);
      check_eq("lb_addr",  a1,  32'h0000_2000);
      check_eq("lb_cycle", wbc, 32'd3);
      check_eq("lb_data",  wbd, 32'hFFFF_FF80);
      check_eq("lb_rd",    {27'h0, wbr}, 32'd5);
      check_eq("lb_ready", {31'h0, rdy}, 32'h1);
      check_eq("lb_pulses", pulses, 32'd1);

      // LBU of the same access
      do_load(3'b100, 32'h0000_2001, 5'd5, 32'h0000_8000, 0, 0, wbc, pulses, reqc, wbd, wbr, a1, rdy);
      check_eq("lbu_data", wbd, 32'h0000_0080);

      // LH from 0x2002 with 3 grant waits and 2 rvalid waits
      do_load(3'b001, 32'h0000_2002, 5'd6, 32'h8001_0000, 3, 2, wbc, pulses, reqc, wbd, wbr, a1, rdy);
      check_eq("lh_cycle", wbc,  32'd8);
      check_eq("lh_data",  wbd,  32'hFFFF_8001);
      check_eq("lh_req_cycles", reqc, 32'd4);

      // LHU, low halfword
      do_load(3'b101, 32'h0000_2000, 5'd7, 32'h1234_F00D, 0, 1, wbc, pulses, reqc, wbd, wbr, a1, rdy);
      check_eq("lhu_data",  wbd, 32'h0000_F00D);
      check_eq("lhu_cycle", wbc, 32'd4);

      // LW to x0: full transaction, no writeback pulse
      do_load(3'b010, 32'h0000_4000, 5'd0, 32'h1234_5678, 0, 0, wbc, pulses, reqc, wbd, wbr, a1, rdy);
      check_eq("lw_x0_req",    reqc,   32'd1);
      check_eq("lw_x0_pulses", pulses, 32'd0);

      // Illegal funct3 load and store are consumed without effect
      issue(1'b0, 3'b011, 32'h0000_7000, 32'h0, 5'd3);
      check_eq("ill_ld_req",   {31'h0, dmem_req},  32'h0);
      check_eq("ill_ld_ready", {31'h0, req_ready}, 32'h1);
      check_eq("ill_ld_addr",  dmem_addr,          32'h0000_4000);
      issue(1'b1, 3'b100, 32'h0000_7004, 32'h55, 5'd0);
      check_eq("ill_st_req",   {31'h0, dmem_req},  32'h0);
      step();

      // Async reset while in RESP, then a stale rvalid
      issue(1'b0, 3'b010, 32'h0000_5000, 32'h0, 5'd9);
      dmem_gnt = 1'b1;
      step();
      dmem_gnt = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      check_eq("arst_ready", {31'h0, req_ready}, 32'h1);
      check_eq("arst_addr",  dmem_addr,          32'h0);
      step();
      rst_n = 1'b1;
      dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
      step();
      dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
      check_eq("arst_wb",     {31'h0, wb_valid},  32'h0);
      check_eq("arst_ready2", {31'h0, req_ready}, 32'h1);
      step();
      check_eq("arst_wb2",    {31'h0, wb_valid},  32'h0);

      // Misaligned word at 0x3002
`ifdef LSU_MISALIGN_TRAP_EN
      issue(1'b0, 3'b010, 32'h0000_3002, 32'h0, 5'd9);
      check_eq("mis_req",     {31'h0, dmem_req},  32'h0);
      check_eq("mis_exc",     {31'h0, exc_valid}, 32'h1);
      check_eq("mis_exc_adr", exc_addr,           32'h0000_3002);
      check_eq("mis_ready",   {31'h0, req_ready}, 32'h1);
      step();
      check_eq("mis_exc_end", {31'h0, exc_valid}, 32'h0);
      check_eq("mis_wb",      {31'h0, wb_valid},  32'h0);
`else
      do_load(3'b010, 32'h0000_3002, 5'd9, 32'hCAFE_F00D, 0, 0, wbc, pulses, reqc, wbd, wbr, a1, rdy);
      check_eq("mis_addr",  a1,  32'h0000_3000);
      check_eq("mis_data",  wbd, 32'hCAFE_F00D);
      check_eq("mis_cycle", wbc, 32'd3);
      check_eq("mis_exc",   {31'h0, exc_valid}, 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   function automatic logic [2:0] F3_SB();
      return 3'b000;
   endfunction

endmodule
`default_nettype wire
